// File: rtl/train_sensor_conditioner_if.sv
// ============================================================================
// Module : train_sensor_conditioner_if
// Brief  : Sensor inputs and conditioned outputs of the track sensor conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface train_sensor_conditioner_if;
    logic raw_w;
    logic raw_e;
    logic clr_fault;
    logic TRW;
    logic TRE;
    logic trw_rise;
    logic tre_rise;
    logic fault_w;
    logic fault_e;

    modport master (
        output raw_w, raw_e, clr_fault,
        input  TRW, TRE, trw_rise, tre_rise, fault_w, fault_e
    );

    modport slave (
        input  raw_w, raw_e, clr_fault,
        output TRW, TRE, trw_rise, tre_rise, fault_w, fault_e
    );
endinterface

`default_nettype wire

// File: rtl/train_sensor_conditioner.sv
// ============================================================================
// Module : train_sensor_conditioner
// Brief  : Per-channel sync, debounce and rise pulse for west/east track sensors.
//          Stuck-sensor detection enabled by macro SENSOR_STUCK_DET_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module train_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int STUCK_CYCLES    = 1024
) (
    input  logic                        clk,
    input  logic                        reset_n,
    train_sensor_conditioner_if.slave   bus
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef SENSOR_STUCK_DET_EN
    localparam int                 c_STK_W    = $clog2(STUCK_CYCLES);
    localparam logic [c_STK_W-1:0] c_STK_LAST = c_STK_W'(STUCK_CYCLES - 1);
`else
    localparam int c_unused_stuck = STUCK_CYCLES;
    logic          w_unused_clr;
    assign w_unused_clr = bus.clr_fault;
`endif

    logic [1:0] w_raw;
    logic [1:0] w_tr;
    logic [1:0] w_rise;
    logic [1:0] w_fault;

    assign w_raw = {bus.raw_e, bus.raw_w};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_ch
            logic               s1_q, s2_q;
            logic               deb_q, deb_d;
            logic [c_CNT_W-1:0] cnt_q, cnt_d;
            logic               tr_prev_q, rise_q;

            always_comb begin
                deb_d = deb_q;
                cnt_d = '0;
                if (s2_q != deb_q) begin
                    if (cnt_q == c_CNT_LAST) begin
                        deb_d = s2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_q      <= 1'b0;
                    s2_q      <= 1'b0;
                    deb_q     <= 1'b0;
                    cnt_q     <= '0;
                    tr_prev_q <= 1'b0;
                    rise_q    <= 1'b0;
                end else begin
                    s1_q      <= w_raw[g];
                    s2_q      <= s1_q;
                    deb_q     <= deb_d;
                    cnt_q     <= cnt_d;
                    tr_prev_q <= w_tr[g];
                    rise_q    <= w_tr[g] & ~tr_prev_q;
                end
            end

`ifdef SENSOR_STUCK_DET_EN
            logic               fault_q, fault_d;
            logic [c_STK_W-1:0] stk_q, stk_d;

            // A set on the same edge as a clear takes priority so a stuck sensor stays flagged.
            always_comb begin
                stk_d   = stk_q;
                fault_d = fault_q;
                if (bus.clr_fault || !deb_q) begin
                    stk_d = '0;
                end else if (stk_q != c_STK_LAST) begin
                    stk_d = stk_q + 1'b1;
                end
                if (deb_q && (stk_q == c_STK_LAST)) begin
                    fault_d = 1'b1;
                end else if (bus.clr_fault) begin
                    fault_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    fault_q <= 1'b0;
                    stk_q   <= '0;
                end else begin
                    fault_q <= fault_d;
                    stk_q   <= stk_d;
                end
            end

            assign w_fault[g] = fault_q;
`else
            assign w_fault[g] = 1'b0;
`endif

            // Fault forces presence so the crossing gate fails closed.
            assign w_tr[g]   = deb_q | w_fault[g];
            assign w_rise[g] = rise_q;
        end
    endgenerate

    assign bus.TRW      = w_tr[0];
    assign bus.TRE      = w_tr[1];
    assign bus.trw_rise = w_rise[0];
    assign bus.tre_rise = w_rise[1];
    assign bus.fault_w  = w_fault[0];
    assign bus.fault_e  = w_fault[1];

endmodule

`default_nettype wire

// File: tb/tb_train_sensor_conditioner.sv
// ============================================================================
// Module : tb_train_sensor_conditioner
// Brief  : Directed, table-driven and randomized checks of the sensor conditioner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_train_sensor_conditioner;

    localparam int D = 4;
    localparam int S = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    train_sensor_conditioner_if bus ();

    train_sensor_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .STUCK_CYCLES    (S)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: a sensor level is accepted once its synchronised value
    // (raw delayed two samples) has disagreed with the level for D samples in a row.
    bit m_s1[2], m_s2[2], m_deb[2], m_fault[2], m_trp[2], m_rise[2], m_trb[2], m_raw[2];
    int m_run[2], m_high[2];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 0; m_s2[c] = 0; m_deb[c] = 0; m_fault[c] = 0;
                m_trp[c] = 0; m_rise[c] = 0; m_run[c] = 0; m_high[c] = 0;
            end
        end else begin
            m_raw[0] = bus.raw_w;
            m_raw[1] = bus.raw_e;
            for (int c = 0; c < 2; c++) begin
                m_trb[c]  = m_deb[c] | m_fault[c];
                m_rise[c] = m_trb[c] && !m_trp[c];
                m_trp[c]  = m_trb[c];
`ifdef SENSOR_STUCK_DET_EN
                if (m_deb[c] && m_high[c] >= S - 1) m_fault[c] = 1;
                else if (bus.clr_fault)             m_fault[c] = 0;
                if (bus.clr_fault || !m_deb[c]) m_high[c] = 0;
                else                            m_high[c]++;
`endif
                if (m_s2[c] != m_deb[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_deb[c] = m_s2[c];
                        m_run[c] = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = m_raw[c];
            end
        end
    end

    task automatic cmp_model(input string tag);
        chk({tag, ".TRW"},      bus.TRW,      m_deb[0] | m_fault[0]);
        chk({tag, ".TRE"},      bus.TRE,      m_deb[1] | m_fault[1]);
        chk({tag, ".trw_rise"}, bus.trw_rise, m_rise[0]);
        chk({tag, ".tre_rise"}, bus.tre_rise, m_rise[1]);
        chk({tag, ".fault_w"},  bus.fault_w,  m_fault[0]);
        chk({tag, ".fault_e"},  bus.fault_e,  m_fault[1]);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".TRW"},      bus.TRW,      1'b0);
        chk({tag, ".TRE"},      bus.TRE,      1'b0);
        chk({tag, ".trw_rise"}, bus.trw_rise, 1'b0);
        chk({tag, ".tre_rise"}, bus.tre_rise, 1'b0);
        chk({tag, ".fault_w"},  bus.fault_w,  1'b0);
        chk({tag, ".fault_e"},  bus.fault_e,  1'b0);
    endtask

    typedef struct {
        logic w;
        logic e;
        int   hold;
        logic exp_w;
        logic exp_e;
    } vec_t;

    vec_t vt[8];
    int   hold_w, hold_e;

    initial begin
        vt[0] = '{w: 1, e: 0, hold: 5, exp_w: 0, exp_e: 0};
        vt[1] = '{w: 1, e: 0, hold: 1, exp_w: 1, exp_e: 0};
        vt[2] = '{w: 1, e: 1, hold: 8, exp_w: 1, exp_e: 1};
        vt[3] = '{w: 0, e: 1, hold: 5, exp_w: 1, exp_e: 1};
        vt[4] = '{w: 0, e: 1, hold: 1, exp_w: 0, exp_e: 1};
        vt[5] = '{w: 0, e: 0, hold: 8, exp_w: 0, exp_e: 0};
        vt[6] = '{w: 1, e: 1, hold: 6, exp_w: 1, exp_e: 1};
        vt[7] = '{w: 0, e: 0, hold: 8, exp_w: 0, exp_e: 0};

        bus.raw_w     = 1'b0;
        bus.raw_e     = 1'b0;
        bus.clr_fault = 1'b0;
        repeat (3) tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        repeat (4) tick();

        // West rises: level after edge D+2, one rise pulse on the following edge.
        bus.raw_w = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t1.TRW", bus.TRW, (k >= 6));
            chk("t1.trw_rise", bus.trw_rise, (k == 7));
            chk("t1.TRE", bus.TRE, 1'b0);
        end

        // West falls: level drops after edge D+2, no pulse.
        bus.raw_w = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t4.TRW", bus.TRW, (k < 6));
            chk("t4.trw_rise", bus.trw_rise, 1'b0);
        end

        // East glitch of three samples is filtered.
        bus.raw_e = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            if (k == 4) bus.raw_e = 1'b0;
            tick();
            chk("t2.TRE", bus.TRE, 1'b0);
            chk("t2.tre_rise", bus.tre_rise, 1'b0);
        end

        // West bounce, then steady high.
        bus.raw_w = 1'b1; tick();
        bus.raw_w = 1'b0; tick();
        bus.raw_w = 1'b1; tick();
        bus.raw_w = 1'b0; tick();
        bus.raw_w = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("t3.TRW", bus.TRW, (k >= 6));
        end
        bus.raw_w = 1'b0;
        repeat (10) tick();

        // Both channels rise together.
        bus.raw_w = 1'b1;
        bus.raw_e = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t5.TRW", bus.TRW, (k >= 6));
            chk("t5.TRE", bus.TRE, (k >= 6));
            chk("t5.trw_rise", bus.trw_rise, (k == 7));
            chk("t5.tre_rise", bus.tre_rise, (k == 7));
        end

        // Asynchronous reset clears outputs before the next edge; restart latency.
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        bus.raw_e = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            chk("rst_restart.TRW", bus.TRW, (k >= 6));
        end
        bus.raw_w = 1'b0;
        repeat (10) tick();

        for (int i = 0; i < 8; i++) begin
            bus.raw_w = vt[i].w;
            bus.raw_e = vt[i].e;
            repeat (vt[i].hold) tick();
            chk($sformatf("vec%0d.TRW", i), bus.TRW, vt[i].exp_w);
            chk($sformatf("vec%0d.TRE", i), bus.TRE, vt[i].exp_e);
        end

`ifdef SENSOR_STUCK_DET_EN
        // East held high latches a stuck fault S edges after TRE rose.
        bus.raw_e = 1'b1;
        repeat (6) tick();
        chk("t6.TRE_up", bus.TRE, 1'b1);
        for (int k = 1; k <= S; k++) begin
            tick();
            chk("t6.fault_e", bus.fault_e, (k == S));
            chk("t6.tre_rise", bus.tre_rise, (k == 1));
        end
        bus.raw_e = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("t6.TRE_held", bus.TRE, 1'b1);
            chk("t6.tre_rise_none", bus.tre_rise, 1'b0);
        end
        chk("t6.fault_w", bus.fault_w, 1'b0);
        bus.clr_fault = 1'b1;
        tick();
        bus.clr_fault = 1'b0;
        chk("t6.fault_e_clr", bus.fault_e, 1'b0);
        chk("t6.TRE_clr", bus.TRE, 1'b0);
        bus.raw_e = 1'b1;
        repeat (S + 4) tick();
        chk("t6.fault_e_again", bus.fault_e, 1'b1);
        reset_n = 1'b0;
        #1;
        chk_all_zero("t6.async_rst");
        bus.raw_e = 1'b0;
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
`endif

        // Randomized run against the model.
        hold_w = 1;
        hold_e = 1;
        for (int i = 0; i < 1500; i++) begin
            if (--hold_w == 0) begin
                bus.raw_w = ~bus.raw_w;
                hold_w = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 12);
            end
            if (--hold_e == 0) begin
                bus.raw_e = ~bus.raw_e;
                hold_e = ($urandom_range(0, 7) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 12);
            end
            bus.clr_fault = ($urandom_range(0, 63) == 0);
            if (i == 700) begin
                reset_n = 1'b0;
                #1;
                cmp_model("rnd_rst");
                tick();
                reset_n = 1'b1;
            end
            tick();
            cmp_model("rnd");
        end
        bus.clr_fault = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
